// File: rtl/yutorina_muldiv_seq.sv
// yutorina_muldiv_seq: multi-cycle unsigned MULU/DIVU/REMU sequencer.
// Iterates ADD/SUB/SLTU through one external ALU, one op per cycle.
//
// Ports:
//   clk, reset_      clock, async active-low reset
//   start, md_op     request (IDLE only); 00 MULU, 01 DIVU, 10 REMU, 11 rsvd
//   lhs, rhs         operands, captured on acceptance
//   flush            abort current operation
//   busy, done       status; done is a one-cycle pulse
//   result, div_zero final value and divide-by-zero flag
//   alu_op/lhs/rhs   ALU drive; alu_ret is the same-cycle ALU result
//
// Build option: MULDIV_EARLY_OUT_EN ends MULU once the multiplier is
// exhausted; results are identical, only latency differs.

module yutorina_muldiv_seq #(
  parameter int              DATA_W    = 32,
  parameter int              CNT_W     = 6,
  parameter int              OP_W      = 4,
  parameter logic [OP_W-1:0] ALU_OP_ADD  = OP_W'(0),
  parameter logic [OP_W-1:0] ALU_OP_SUB  = OP_W'(1),
  parameter logic [OP_W-1:0] ALU_OP_SLTU = OP_W'(3)
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  input  logic [1:0]        md_op,
  input  logic [DATA_W-1:0] lhs,
  input  logic [DATA_W-1:0] rhs,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div_zero,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_lhs,
  output logic [DATA_W-1:0] alu_rhs,
  input  logic [DATA_W-1:0] alu_ret
);

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_CMP,
    DIV_SUB,
    DONE
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic              rem_hi;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;
  logic              ge;
  logic [DATA_W-1:0] res_q;
  logic              dz_q;

  logic [DATA_W-1:0] acc_n;
  logic [DATA_W-1:0] mplier_n;
  logic [DATA_W-1:0] rem_n;
  logic [DATA_W-1:0] quo_n;
  logic              last;
  logic              mul_end;

  always_comb begin
    alu_op  = ALU_OP_ADD;
    alu_lhs = '0;
    alu_rhs = '0;
    unique case (state)
      MUL: begin
        alu_lhs = acc;
        alu_rhs = mcand;
      end
      DIV_CMP: begin
        alu_op  = ALU_OP_SLTU;
        alu_lhs = rem;
        alu_rhs = divisor;
      end
      DIV_SUB: begin
        alu_op  = ALU_OP_SUB;
        alu_lhs = rem;
        alu_rhs = divisor;
      end
      default: ;
    endcase
  end

  // Per-iteration updates before the shift.
  always_comb begin
    acc_n    = mplier[0] ? alu_ret : acc;
    mplier_n = mplier >> 1;
    rem_n    = ge ? alu_ret : rem;
    quo_n    = {quo[DATA_W-1:1], ge};
    last     = (cnt == CNT_W'(DATA_W - 1));
`ifdef MULDIV_EARLY_OUT_EN
    mul_end  = last || (mplier_n == '0);
`else
    mul_end  = last;
`endif
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
      op_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem_hi   <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      ge       <= 1'b0;
      res_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Also drops a start in IDLE; result/div_zero stay untouched.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              busy     <= 1'b1;
              div_zero <= 1'b0;
              dz_q     <= 1'b0;
              op_q     <= md_op;
              cnt      <= '0;
              unique case (md_op)
                OP_MULU: begin
                  acc    <= '0;
                  mcand  <= lhs;
                  mplier <= rhs;
                  state  <= MUL;
`ifdef MULDIV_EARLY_OUT_EN
                  if (rhs == '0) begin
                    res_q <= '0;
                    state <= DONE;
                  end
`endif
                end
                OP_DIVU, OP_REMU: begin
                  if (rhs == '0) begin
                    res_q <= (md_op == OP_DIVU) ? '1 : lhs;
                    dz_q  <= 1'b1;
                    state <= DONE;
                  end else begin
                    // Dividend MSB enters rem; the rest waits in quo.
                    rem_hi  <= 1'b0;
                    rem     <= {{(DATA_W-1){1'b0}}, lhs[DATA_W-1]};
                    quo     <= lhs << 1;
                    divisor <= rhs;
                    state   <= DIV_CMP;
                  end
                end
                default: begin
                  res_q <= '0;
                  state <= DONE;
                end
              endcase
            end
          end
          MUL: begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier_n;
            cnt    <= cnt + CNT_W'(1);
            if (mul_end) begin
              res_q <= acc_n;
              state <= DONE;
            end
          end
          DIV_CMP: begin
            // rem_hi set means rem exceeds any divisor.
            ge    <= rem_hi | (alu_ret == '0);
            state <= DIV_SUB;
          end
          DIV_SUB: begin
            if (last) begin
              res_q <= (op_q == OP_DIVU) ? quo_n : rem_n;
              state <= DONE;
            end else begin
              rem_hi <= rem_n[DATA_W-1];
              rem    <= {rem_n[DATA_W-2:0], quo_n[DATA_W-1]};
              quo    <= {quo_n[DATA_W-2:0], 1'b0};
              cnt    <= cnt + CNT_W'(1);
              state  <= DIV_CMP;
            end
          end
          DONE: begin
            done     <= 1'b1;
            busy     <= 1'b0;
            result   <= res_q;
            div_zero <= dz_q;
            state    <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yutorina_muldiv_seq.sv
// tb_yutorina_muldiv_seq: directed + random MULU/DIVU/REMU checks
// against an arithmetic reference, with a behavioural ALU.

module tb_yutorina_muldiv_seq;

  logic        clk;
  logic        reset_;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_lhs;
  logic [31:0] alu_rhs;
  logic [31:0] alu_ret;

  int n_tests = 0;
  int n_fail  = 0;

  yutorina_muldiv_seq dut (
    .clk      (clk),
    .reset_   (reset_),
    .start    (start),
    .md_op    (md_op),
    .lhs      (lhs),
    .rhs      (rhs),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero),
    .alu_op   (alu_op),
    .alu_lhs  (alu_lhs),
    .alu_rhs  (alu_rhs),
    .alu_ret  (alu_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'd0:    alu_ret = alu_lhs + alu_rhs;
      4'd1:    alu_ret = alu_lhs - alu_rhs;
      4'd3:    alu_ret = (alu_lhs < alu_rhs) ? 32'd1 : 32'd0;
      default: alu_ret = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      2'b00:   return a * b;
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op,
                                 input logic [31:0] b);
    int lat;
    lat = 1;
    if (op == 2'b00) begin
`ifdef MULDIV_EARLY_OUT_EN
      for (int i = 0; i < 32; i++)
        if (b[i]) lat = i + 2;
`else
      lat = 33;
`endif
    end else if (op != 2'b11 && b != 0) begin
      lat = 65;
    end
    return lat;
  endfunction

  // Call with the DUT idle and start low, before a rising edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp_r;
    int exp_l;
    int lat;
    int busy_bad;
    exp_r = ref_res(op, a, b);
    exp_l = ref_lat(op, b);
    md_op = op;
    lhs   = a;
    rhs   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    busy_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      if (busy !== 1'b1) busy_bad++;
      // Junk requests while busy must be ignored.
      start = 1'($urandom_range(0, 1));
      md_op = 2'($urandom_range(0, 3));
      lhs   = $urandom;
      rhs   = $urandom;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_l));
    chk("busy_during", 64'(busy_bad), 64'd0);
    chk("result", {32'd0, result}, {32'd0, exp_r});
    chk("div_zero", {63'd0, div_zero},
        {63'd0, (op == 2'b01 || op == 2'b10) && b == 0});
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("alu_idle", {alu_op, alu_lhs, alu_rhs}, 68'd0);
    @(posedge clk);
    #1;
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("result_hold", {32'd0, result}, {32'd0, exp_r});
  endtask

  logic [31:0] prev;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  int          seen;

  initial begin
    reset_ = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    md_op  = 2'b00;
    lhs    = '0;
    rhs    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    chk("rst_alu", {alu_op, alu_lhs, alu_rhs}, 68'd0);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;

    run_op(2'b00, 32'd7, 32'd6);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b01, 32'd100, 32'd7);
    run_op(2'b10, 32'd100, 32'd7);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1);
    run_op(2'b01, 32'd5, 32'd0);
    run_op(2'b10, 32'd5, 32'd0);
    run_op(2'b11, 32'd9, 32'd9);
    run_op(2'b00, 32'd123, 32'd0);
    run_op(2'b01, 32'd3, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'h8000_0001);

    // Flush ten cycles into a divide.
    prev  = result;
    md_op = 2'b01;
    lhs   = 32'd100;
    rhs   = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (80) begin
      if (done === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    chk("flush_nodone", 64'(seen), 64'd0);
    chk("flush_result", {32'd0, result}, {32'd0, prev});
    run_op(2'b00, 32'd3, 32'd3);

    // Flush and start together in IDLE: start is dropped.
    md_op = 2'b11;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    chk("flush_start_nodone", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    run_op(2'b10, 32'd5, 32'd0);
    md_op = 2'b00;
    lhs   = 32'd3;
    rhs   = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_ = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_result", {32'd0, result}, 64'd0);
    chk("arst_dz", {63'd0, div_zero}, 64'd0);
    chk("arst_alu", {alu_op, alu_lhs, alu_rhs}, 68'd0);
    @(negedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    run_op(2'b00, 32'd7, 32'd6);

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'd0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
